ibex_noc_tx_arbiter: RTL and testbench

- Shares one NoC injection port among NumCores Ibex cores.
- Each core presents a message through its custom NoC request interface. A message is 1–4 words: the output data word plus msg1/msg2/msg3, selected by length.
- The block arbitrates round-robin, captures the winning message into a local buffer, and returns a grant.
- It then serialises the message as head/body/tail flits over a valid/ready link to the router.
- Sits between the per-core noc_req/noc_gnt ports and the router ingress.

---
 rtl/ibex_noc_pkg.sv | 23 ++
 rtl/ibex_noc_rr_arb.sv | 29 ++
 rtl/ibex_noc_tx_arbiter.sv | 93 +++++++++
 tb/tb_ibex_noc_tx_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ibex_noc_pkg.sv
// ibex_noc_pkg: shared widths, message/flit records and FSM states for the NoC TX path
package ibex_noc_pkg;
  localparam int NOC_ID_W = 5;
  localparam int NOC_LEN_W = 2;
  localparam int NOC_DATA_W = 32;
  localparam int NOC_MAX_WORDS = 4;
  typedef enum logic {ST_IDLE, ST_SEND} noc_state_e;
  typedef struct packed {
    logic [NOC_ID_W-1:0] dst;
    logic [NOC_ID_W-1:0] addr;
    logic [NOC_LEN_W-1:0] len;
    logic [NOC_MAX_WORDS-1:0][NOC_DATA_W-1:0] data;
  } noc_msg_t;
  typedef struct packed {
    logic head;
    logic tail;
    logic [NOC_ID_W-1:0] src;
    logic [NOC_ID_W-1:0] dst;
    logic [NOC_ID_W-1:0] addr;
    logic [NOC_LEN_W-1:0] len;
    logic [NOC_DATA_W-1:0] data;
  } noc_flit_t;
endpackage

// File: rtl/ibex_noc_rr_arb.sv
// ibex_noc_rr_arb: combinational pick of the first request at or after the pointer, wrapping
module ibex_noc_rr_arb #(
  parameter int NumCores = 4,
  parameter int IdxW = 2
) (
  input  logic [NumCores-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic [NumCores-1:0] win_oh_o,
  output logic [IdxW-1:0]     win_idx_o,
  output logic                valid_o
);
  function automatic int wrap(input int v);
    return v % NumCores;
  endfunction
  logic found;
  always_comb begin
    win_oh_o = '0;
    win_idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NumCores; i++) begin
      if (!found && req_i[wrap(int'(ptr_i) + i)]) begin
        found = 1'b1;
        win_oh_o[wrap(int'(ptr_i) + i)] = 1'b1;
        win_idx_o = IdxW'(wrap(int'(ptr_i) + i));
      end
    end
    valid_o = |req_i;
  end
endmodule

// File: rtl/ibex_noc_tx_arbiter.sv
// ibex_noc_tx_arbiter: round-robin share of one NoC injection port, serialising messages as flits
module ibex_noc_tx_arbiter import ibex_noc_pkg::*; #(
  parameter int NumCores = 4,
  parameter int CoreIdBase = 0
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NumCores-1:0]                      req_i,
  input  logic [NumCores-1:0][NOC_LEN_W-1:0]       len_i,
  input  logic [NumCores-1:0][NOC_ID_W-1:0]        dst_core_i,
  input  logic [NumCores-1:0][NOC_ID_W-1:0]        dst_addr_i,
  input  logic [NumCores-1:0][NOC_MAX_WORDS-1:0][NOC_DATA_W-1:0] data_i,
  output logic [NumCores-1:0]                      gnt_o,
  output logic                                     flit_valid_o,
  input  logic                                     flit_ready_i,
  output logic                                     flit_head_o,
  output logic                                     flit_tail_o,
  output logic [NOC_ID_W-1:0]                      flit_src_o,
  output logic [NOC_ID_W-1:0]                      flit_dst_o,
  output logic [NOC_ID_W-1:0]                      flit_addr_o,
  output logic [NOC_LEN_W-1:0]                     flit_len_o,
  output logic [NOC_DATA_W-1:0]                    flit_data_o,
  output logic                                     busy_o
);
  localparam int IdxW = (NumCores > 1) ? $clog2(NumCores) : 1;
  noc_state_e state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d, win_idx;
  logic [NOC_LEN_W-1:0] idx_q, idx_d;
  logic [NumCores-1:0] gnt_q, gnt_d, win_oh;
  logic [NOC_ID_W-1:0] src_q, src_d;
  noc_msg_t msg_q, msg_d;
  noc_flit_t flit;
  logic win_vld, send, last;
  ibex_noc_rr_arb #(.NumCores(NumCores), .IdxW(IdxW)) u_arb (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .win_oh_o (win_oh),
    .win_idx_o(win_idx),
    .valid_o  (win_vld)
  );
  always_comb begin
    send = state_q == ST_SEND;
    last = idx_q == msg_q.len;
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    msg_d = msg_q;
    src_d = src_q;
    gnt_d = '0;
    if (!send && win_vld) begin
      state_d = ST_SEND;
      ptr_d = (int'(win_idx) == NumCores - 1) ? '0 : win_idx + 1'b1;
      idx_d = '0;
      gnt_d = win_oh;
      msg_d = '{dst: dst_core_i[win_idx], addr: dst_addr_i[win_idx], len: len_i[win_idx],
                data: data_i[win_idx]};
      src_d = NOC_ID_W'(CoreIdBase + int'(win_idx));
    end else if (send && flit_ready_i) begin
      state_d = last ? ST_IDLE : ST_SEND;
      idx_d = last ? idx_q : idx_q + 1'b1;
    end
    // Outside SEND every flit field reads as zero.
    flit = send ? '{head: idx_q == '0, tail: last, src: src_q, dst: msg_q.dst, addr: msg_q.addr,
                    len: msg_q.len, data: msg_q.data[idx_q]} : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      gnt_q <= '0;
      msg_q <= '0;
      src_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      gnt_q <= gnt_d;
      msg_q <= msg_d;
      src_q <= src_d;
    end
  end
  assign gnt_o = gnt_q;
  assign flit_valid_o = send;
  assign busy_o = send;
  assign flit_head_o = flit.head;
  assign flit_tail_o = flit.tail;
  assign flit_src_o = flit.src;
  assign flit_dst_o = flit.dst;
  assign flit_addr_o = flit.addr;
  assign flit_len_o = flit.len;
  assign flit_data_o = flit.data;
endmodule

// File: tb/tb_ibex_noc_tx_arbiter.sv
// tb_ibex_noc_tx_arbiter: directed vector table plus multi-cycle sequences for the NoC TX arbiter
module tb_ibex_noc_tx_arbiter;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [3:0] req = '0;
  logic [3:0][1:0] len = '0;
  logic [3:0][4:0] dst = '0, addr = '0;
  logic [3:0][3:0][31:0] data = '0;
  logic [3:0] gnt_o;
  logic flit_valid_o, flit_ready = 1'b1, flit_head_o, flit_tail_o, busy_o;
  logic [4:0] flit_src_o, flit_dst_o, flit_addr_o;
  logic [1:0] flit_len_o;
  logic [31:0] flit_data_o;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ibex_noc_tx_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .len_i(len), .dst_core_i(dst), .dst_addr_i(addr),
    .data_i(data), .gnt_o(gnt_o), .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready),
    .flit_head_o(flit_head_o), .flit_tail_o(flit_tail_o), .flit_src_o(flit_src_o),
    .flit_dst_o(flit_dst_o), .flit_addr_o(flit_addr_o), .flit_len_o(flit_len_o),
    .flit_data_o(flit_data_o), .busy_o(busy_o)
  );
  typedef struct {
    int core;
    logic [1:0] len;
    logic [4:0] dst, addr;
    logic [3:0][31:0] w;
    logic [3:0] exp_gnt;
    logic [4:0] exp_src;
  } vec_t;
  vec_t tbl[4];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_ni = 1'b0;
    req = '0;
    step();
    step();
    rst_ni = 1'b1;
  endtask
  task automatic set_msg(input int c, input logic [1:0] l, input logic [4:0] d, input logic [4:0] a,
                         input logic [3:0][31:0] w);
    len[c] = l;
    dst[c] = d;
    addr[c] = a;
    data[c] = w;
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_valid"}, 64'(flit_valid_o), 64'd0);
    chk({name, "_busy"}, 64'(busy_o), 64'd0);
    chk({name, "_gnt"}, 64'(gnt_o), 64'd0);
    chk({name, "_data"}, 64'(flit_data_o), 64'd0);
  endtask
  int got[6];
  int ng;
  logic [3:0] prev_gnt;
  initial begin
    tbl[0] = '{core: 2, len: 2'd0, dst: 5'd7, addr: 5'd3, w: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
               exp_gnt: 4'b0100, exp_src: 5'd2};
    tbl[1] = '{core: 1, len: 2'd1, dst: 5'h1f, addr: 5'd0, w: {32'h0, 32'h0, 32'h22220000, 32'h11110000},
               exp_gnt: 4'b0010, exp_src: 5'd1};
    tbl[2] = '{core: 3, len: 2'd2, dst: 5'd0, addr: 5'h1e, w: {32'h0, 32'hC, 32'hB, 32'hA},
               exp_gnt: 4'b1000, exp_src: 5'd3};
    tbl[3] = '{core: 0, len: 2'd3, dst: 5'd12, addr: 5'd9, w: {32'h4, 32'h3, 32'h2, 32'h1},
               exp_gnt: 4'b0001, exp_src: 5'd0};
    do_reset();
    chk_idle("reset");
    chk("reset_head", 64'(flit_head_o), 64'd0);
    chk("reset_tail", 64'(flit_tail_o), 64'd0);
    chk("reset_src", 64'(flit_src_o), 64'd0);
    for (int v = 0; v < 4; v++) begin
      set_msg(tbl[v].core, tbl[v].len, tbl[v].dst, tbl[v].addr, tbl[v].w);
      req[tbl[v].core] = 1'b1;
      step();
      chk($sformatf("v%0d_gnt", v), 64'(gnt_o), 64'(tbl[v].exp_gnt));
      req = '0;
      for (int k = 0; k <= int'(tbl[v].len); k++) begin
        chk($sformatf("v%0d_f%0d_valid", v, k), 64'(flit_valid_o), 64'd1);
        chk($sformatf("v%0d_f%0d_busy", v, k), 64'(busy_o), 64'd1);
        chk($sformatf("v%0d_f%0d_head", v, k), 64'(flit_head_o), 64'(k == 0));
        chk($sformatf("v%0d_f%0d_tail", v, k), 64'(flit_tail_o), 64'(k == int'(tbl[v].len)));
        chk($sformatf("v%0d_f%0d_src", v, k), 64'(flit_src_o), 64'(tbl[v].exp_src));
        chk($sformatf("v%0d_f%0d_dst", v, k), 64'(flit_dst_o), 64'(tbl[v].dst));
        chk($sformatf("v%0d_f%0d_addr", v, k), 64'(flit_addr_o), 64'(tbl[v].addr));
        chk($sformatf("v%0d_f%0d_len", v, k), 64'(flit_len_o), 64'(tbl[v].len));
        chk($sformatf("v%0d_f%0d_data", v, k), 64'(flit_data_o), 64'(tbl[v].w[k]));
        if (k > 0) chk($sformatf("v%0d_f%0d_gnt", v, k), 64'(gnt_o), 64'd0);
        step();
      end
      chk_idle($sformatf("v%0d_end", v));
    end
    // Backpressure on the second flit of a 4-word message.
    do_reset();
    set_msg(0, 2'd3, 5'd1, 5'd2, {32'h44, 32'h33, 32'h22, 32'h11});
    req[0] = 1'b1;
    step();
    req = '0;
    chk("bp_gnt", 64'(gnt_o), 64'b0001);
    chk("bp_f0", {flit_head_o, flit_tail_o, flit_data_o}, {2'b10, 32'h11});
    step();
    flit_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("bp_stall%0d", s), {flit_valid_o, flit_head_o, flit_tail_o, flit_src_o,
          flit_dst_o, flit_addr_o, flit_len_o, flit_data_o},
          {3'b100, 5'd0, 5'd1, 5'd2, 2'd3, 32'h22});
      step();
    end
    flit_ready = 1'b1;
    chk("bp_f1", {flit_valid_o, flit_head_o, flit_tail_o, flit_data_o}, {3'b100, 32'h22});
    step();
    chk("bp_f2", {flit_valid_o, flit_head_o, flit_tail_o, flit_data_o}, {3'b100, 32'h33});
    step();
    chk("bp_f3", {flit_valid_o, flit_head_o, flit_tail_o, flit_data_o}, {3'b101, 32'h44});
    step();
    chk_idle("bp_end");
    // All four cores requesting continuously.
    do_reset();
    for (int c = 0; c < 4; c++) set_msg(c, 2'd0, 5'(c), 5'(c), {4{32'(c + 100)}});
    req = 4'hf;
    ng = 0;
    prev_gnt = '0;
    for (int i = 0; i < 6; i++) got[i] = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      chk($sformatf("rr_onehot%0d", cyc), 64'($countones(gnt_o) <= 1), 64'd1);
      chk($sformatf("rr_nodouble%0d", cyc), 64'(gnt_o & prev_gnt), 64'd0);
      prev_gnt = gnt_o;
      for (int c = 0; c < 4; c++) if (gnt_o[c] && ng < 6) begin
        got[ng] = c;
        ng++;
      end
    end
    req = '0;
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), 64'(got[i]), 64'(i % 4));
    step();
    step();
    // Pointer at 1 with cores 0 and 3 requesting.
    do_reset();
    req = 4'b0001;
    step();
    req = '0;
    chk("wrap_first", 64'(gnt_o), 64'b0001);
    step();
    req = 4'b1001;
    step();
    chk("wrap_c3", 64'(gnt_o), 64'b1000);
    chk("wrap_c3_src", 64'(flit_src_o), 64'd3);
    req = 4'b0001;
    step();
    chk("wrap_gap", 64'(gnt_o), 64'd0);
    step();
    chk("wrap_c0", 64'(gnt_o), 64'b0001);
    req = '0;
    step();
    step();
    // Reset in the middle of a 3-flit message.
    do_reset();
    set_msg(1, 2'd2, 5'd4, 5'd5, {32'h0, 32'h3C, 32'h2B, 32'h1A});
    req = 4'b0010;
    step();
    chk("rst_gnt", 64'(gnt_o), 64'b0010);
    req = '0;
    step();
    chk("rst_f1", 64'(flit_data_o), 64'h2B);
    rst_ni = 1'b0;
    step();
    chk_idle("rst_abort");
    rst_ni = 1'b1;
    req = 4'b1010;
    step();
    chk("rst_lowest", 64'(gnt_o), 64'b0010);
    req = '0;
    for (int s = 0; s < 3; s++) step();
    // Back-to-back messages from one core.
    do_reset();
    set_msg(1, 2'd1, 5'd6, 5'd7, {32'h0, 32'h0, 32'hB1, 32'hA1});
    req = 4'b0010;
    step();
    chk("b2b_gnt1", 64'(gnt_o), 64'b0010);
    chk("b2b_a", {flit_head_o, flit_tail_o, flit_data_o}, {2'b10, 32'hA1});
    set_msg(1, 2'd1, 5'd6, 5'd7, {32'h0, 32'h0, 32'hD2, 32'hC2});
    step();
    chk("b2b_b", {flit_head_o, flit_tail_o, flit_data_o}, {2'b01, 32'hB1});
    chk("b2b_b_gnt", 64'(gnt_o), 64'd0);
    step();
    chk("b2b_idle_valid", 64'(flit_valid_o), 64'd0);
    chk("b2b_idle_gnt", 64'(gnt_o), 64'd0);
    step();
    chk("b2b_gnt2", 64'(gnt_o), 64'b0010);
    chk("b2b_c", {flit_head_o, flit_tail_o, flit_data_o}, {2'b10, 32'hC2});
    req = '0;
    step();
    chk("b2b_d", {flit_head_o, flit_tail_o, flit_data_o}, {2'b01, 32'hD2});
    step();
    chk_idle("b2b_end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
